imem_wb_bridge: RTL and testbench

- Instruction-memory bridge directly upstream of the fetch stage.
- Accepts the fetch stage's strobe/address request and runs one Wishbone classic read cycle on the instruction bus per request.
- Returns the instruction word with a single-cycle ack.
- Converts bus errors, timeouts and misaligned fetches into a NOP plus a fault indication, so the pipeline never hangs.

---
 rtl/imem_wb_bridge.sv | 105 ++++++++++
 tb/tb_imem_wb_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_wb_bridge.sv
// Instruction-memory bridge: turns fetch-stage strobe/address requests into
// Wishbone classic reads, and turns errors, timeouts and misaligned fetches into a NOP plus a fault flag.
module imem_wb_bridge #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_Imem_stb,
  input  logic [31:0] i_Iaddr,
  output logic [31:0] o_Inst,
  output logic        o_Imem_ack,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_fault,
  output logic [31:0] o_fault_addr
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          fault_q;

  // The ack, fault and bus handshake are decoded from state only.
  // This keeps every path from an input to an output behind a flop.
  assign o_wb_cyc   = (state == BUS);
  assign o_wb_stb   = (state == BUS);
  assign o_wb_we    = 1'b0;
  assign o_wb_sel   = 4'hF;
  assign o_Imem_ack = (state == RESP);
  assign o_fault    = (state == RESP) && fault_q;
  assign o_Inst     = data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      data_q       <= NOP_WORD;
      fault_q      <= 1'b0;
      o_fault_addr <= '0;
      o_wb_adr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Imem_stb) begin
            if (i_Iaddr[1:0] == 2'b00) begin
              addr_q   <= i_Iaddr;
              o_wb_adr <= {i_Iaddr[31:2], 2'b00};
              cnt      <= '0;
              state    <= BUS;
            end else begin
              data_q       <= NOP_WORD;
              fault_q      <= 1'b1;
              o_fault_addr <= i_Iaddr;
              state        <= RESP;
            end
          end
        end
        BUS: begin
          // A request withdrawn on the terminating cycle is dropped silently.
          if (i_wb_err || i_wb_ack || cnt == LAST) begin
            if (!i_Imem_stb) begin
              state <= IDLE;
            end else if (i_wb_ack && !i_wb_err) begin
              data_q  <= i_wb_dat;
              fault_q <= 1'b0;
              state   <= RESP;
            end else begin
              data_q       <= NOP_WORD;
              fault_q      <= 1'b1;
              o_fault_addr <= addr_q;
              state        <= RESP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_wb_bridge.sv
// Directed bench for imem_wb_bridge with TIMEOUT = 4: hand-computed expectations checked by
// immediate assertions after each clock.
module tb_imem_wb_bridge;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_Imem_stb = 1'b0;
  logic [31:0] i_Iaddr = '0;
  logic [31:0] o_Inst;
  logic        o_Imem_ack;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_adr;
  logic [31:0] i_wb_dat = '0;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_err = 1'b0;
  logic        o_fault;
  logic [31:0] o_fault_addr;

  int vectors = 0;
  int miscompares = 0;

  imem_wb_bridge #(.TIMEOUT(4), .NOP_WORD(NOP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_Imem_stb(i_Imem_stb),
    .i_Iaddr(i_Iaddr),
    .o_Inst(o_Inst),
    .o_Imem_ack(o_Imem_ack),
    .o_wb_cyc(o_wb_cyc),
    .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we),
    .o_wb_sel(o_wb_sel),
    .o_wb_adr(o_wb_adr),
    .i_wb_dat(i_wb_dat),
    .i_wb_ack(i_wb_ack),
    .i_wb_err(i_wb_err),
    .o_fault(o_fault),
    .o_fault_addr(o_fault_addr)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic stb, input logic [31:0] addr,
                               input logic ack, input logic err, input logic [31:0] dat);
    i_Imem_stb = stb;
    i_Iaddr    = addr;
    i_wb_ack   = ack;
    i_wb_err   = err;
    i_wb_dat   = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;

    // Reset
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    checkOutput("rst_ack", o_Imem_ack, 0);
    checkOutput("rst_cyc", o_wb_cyc, 0);
    checkOutput("rst_stb", o_wb_stb, 0);
    checkOutput("rst_fault", o_fault, 0);
    checkOutput("rst_inst", o_Inst, NOP);
    checkOutput("rst_faddr", o_fault_addr, 0);
    checkOutput("rst_adr", o_wb_adr, 0);
    checkOutput("we", o_wb_we, 0);
    checkOutput("sel", o_wb_sel, 4'hF);

    // Zero-wait read at 0x100
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_cyc", o_wb_cyc, 1);
    checkOutput("t1_stb", o_wb_stb, 1);
    checkOutput("t1_adr", o_wb_adr, 32'h100);
    checkOutput("t1_ack_early", o_Imem_ack, 0);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h00500093);
    checkOutput("t1_ack", o_Imem_ack, 1);
    checkOutput("t1_inst", o_Inst, 32'h00500093);
    checkOutput("t1_fault", o_fault, 0);
    checkOutput("t1_cyc_resp", o_wb_cyc, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_cyc_after", o_wb_cyc, 0);
    checkOutput("t1_ack_after", o_Imem_ack, 0);
    checkOutput("t1_inst_hold", o_Inst, 32'h00500093);

    // Three wait states at 0x104; address wiggles during BUS must be ignored
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t2_cyc_wait", o_wb_cyc, 1);
      checkOutput("t2_ack_wait", o_Imem_ack, 0);
      checkOutput("t2_adr", o_wb_adr, 32'h104);
      applyStimulus(1'b1, 32'h999, 1'b0, 1'b0, 32'h0);
    end
    checkOutput("t2_cyc_last", o_wb_cyc, 1);
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h00A00113);
    checkOutput("t2_ack", o_Imem_ack, 1);
    checkOutput("t2_inst", o_Inst, 32'h00A00113);
    checkOutput("t2_fault", o_fault, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t2_ack_single", o_Imem_ack, 0);
    checkOutput("t2_no_dup_cyc", o_wb_cyc, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t2_no_dup_cyc2", o_wb_cyc, 0);

    // err and ack together at 0x108: err wins
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b0, 32'h0);
    checkOutput("t3_cyc", o_wb_cyc, 1);
    applyStimulus(1'b1, 32'h108, 1'b1, 1'b1, 32'h12345678);
    checkOutput("t3_ack", o_Imem_ack, 1);
    checkOutput("t3_inst", o_Inst, NOP);
    checkOutput("t3_fault", o_fault, 1);
    checkOutput("t3_faddr", o_fault_addr, 32'h108);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t3_fault_pulse", o_fault, 0);
    checkOutput("t3_ack_pulse", o_Imem_ack, 0);

    // Silent slave at 0x10C: TIMEOUT = 4 cycles of cyc
    applyStimulus(1'b1, 32'h10C, 1'b0, 1'b0, 32'h0);
    n = 0;
    while (o_wb_cyc === 1'b1 && n < 10) begin
      n++;
      applyStimulus(1'b1, 32'h10C, 1'b0, 1'b0, 32'h0);
    end
    checkOutput("t4_cyc_cycles", n, 4);
    checkOutput("t4_ack", o_Imem_ack, 1);
    checkOutput("t4_inst", o_Inst, NOP);
    checkOutput("t4_fault", o_fault, 1);
    checkOutput("t4_faddr", o_fault_addr, 32'h10C);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_ack_after", o_Imem_ack, 0);

    // Misaligned fetch at 0x102: no bus cycle, ack one cycle later
    applyStimulus(1'b1, 32'h102, 1'b0, 1'b0, 32'h0);
    checkOutput("t5_cyc", o_wb_cyc, 0);
    checkOutput("t5_ack", o_Imem_ack, 1);
    checkOutput("t5_inst", o_Inst, NOP);
    checkOutput("t5_fault", o_fault, 1);
    checkOutput("t5_faddr", o_fault_addr, 32'h102);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("t5_ack_after", o_Imem_ack, 0);
    checkOutput("t5_cyc_after", o_wb_cyc, 0);

    // Load a real word so the reset-to-NOP of o_Inst is observable
    applyStimulus(1'b1, 32'h180, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h180, 1'b1, 1'b0, 32'h00B00193);
    checkOutput("t6_pre_inst", o_Inst, 32'h00B00193);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset during the second wait state at 0x200
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_cyc_wait2", o_wb_cyc, 1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    checkOutput("t6_cyc_rst", o_wb_cyc, 0);
    checkOutput("t6_ack_rst", o_Imem_ack, 0);
    checkOutput("t6_inst_rst", o_Inst, NOP);
    checkOutput("t6_faddr_rst", o_fault_addr, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF);
    checkOutput("t6_no_ack", o_Imem_ack, 0);
    checkOutput("t6_no_fault", o_fault, 0);

    // Fresh request after reset completes normally
    applyStimulus(1'b1, 32'h204, 1'b0, 1'b0, 32'h0);
    checkOutput("t7_cyc", o_wb_cyc, 1);
    checkOutput("t7_adr", o_wb_adr, 32'h204);
    applyStimulus(1'b1, 32'h204, 1'b1, 1'b0, 32'h00100073);
    checkOutput("t7_ack", o_Imem_ack, 1);
    checkOutput("t7_inst", o_Inst, 32'h00100073);
    checkOutput("t7_fault", o_fault, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Request withdrawn on the terminating cycle: no ack, fault address kept
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    checkOutput("t8_cyc", o_wb_cyc, 1);
    applyStimulus(1'b0, 32'h300, 1'b0, 1'b1, 32'h0);
    checkOutput("t8_ack", o_Imem_ack, 0);
    checkOutput("t8_fault", o_fault, 0);
    checkOutput("t8_cyc_off", o_wb_cyc, 0);
    checkOutput("t8_faddr", o_fault_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
